// File: rtl/mult_div_unit_pkg.sv
// Shared opcode package: internal opcodes seen by the execute stage and the
// multiply/divide unit FSM states.
package mult_div_unit_pkg;

    typedef enum logic [6:0] {
        ADDU  = 7'd0,
        ADDIU = 7'd1,
        LW    = 7'd2,
        MULT  = 7'd3,
        MULTU = 7'd4,
        DIV   = 7'd5,
        DIVU  = 7'd6,
        MTHI  = 7'd7,
        MTLO  = 7'd8
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // True for the opcodes that run the iterative multiply/divide datapath.
    function automatic logic is_md_op(input opcode_e op);
        return op inside {MULT, MULTU, DIV, DIVU};
    endfunction

endpackage

// File: rtl/mult_div_unit_md_iter_step.sv
// One radix-2 step of the multiply/divide datapath: shift-add for multiply,
// restoring shift-subtract for divide, on unsigned magnitudes.
module md_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_operand,
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    output logic [WIDTH-1:0] o_acc_hi_c,
    output logic [WIDTH-1:0] o_acc_lo_c
);

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;

    // Remainder stays below the divisor, so the difference always fits WIDTH bits.
    always_comb begin
        w_mul_sum   = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_operand} : '0);
        w_div_shift = {i_acc_hi, i_acc_lo[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, i_operand});
        w_div_diff  = w_div_shift[WIDTH-1:0] - i_operand;
        o_acc_hi_c  = w_mul_sum[WIDTH:1];
        o_acc_lo_c  = {w_mul_sum[0], i_acc_lo[WIDTH-1:1]};
        if (i_is_div) begin
            o_acc_hi_c = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            o_acc_lo_c = {i_acc_lo[WIDTH-2:0], w_div_ge};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers;
// one result bit per cycle, sign handled by magnitude in / sign fix-up out.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  opcode_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz_out;

    logic               w_take;
    logic               w_accept_md;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic               w_iter;
    logic               w_finish;
    logic               w_is_div_op;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Next state; cancel also drops a coincident start.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_accept_md = 1'b0;
        w_wr_hi     = 1'b0;
        w_wr_lo     = 1'b0;
        w_iter      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                w_take      = start && !cancel;
                if (w_take && is_md_op(op)) begin
                    w_accept_md = 1'b1;
                    w_state_nxt = RUN;
                end
                w_wr_hi = w_take && (op == MTHI);
                w_wr_lo = w_take && (op == MTLO);
            end
            RUN: begin
                if (cancel) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_iter = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand magnitudes and signs at acceptance.
    always_comb begin
        w_is_div_op = (op == DIV) || (op == DIVU);
        w_signed    = (op == MULT) || (op == DIV);
        w_a_neg     = w_signed && a[WIDTH-1];
        w_b_neg     = w_signed && b[WIDTH-1];
        w_a_mag     = w_a_neg ? ('0 - a) : a;
        w_b_mag     = w_b_neg ? ('0 - b) : b;
    end

    md_iter_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .i_is_div   (r_is_div),
        .i_operand  (r_operand),
        .i_acc_hi   (r_acc_hi),
        .i_acc_lo   (r_acc_lo),
        .o_acc_hi_c (w_step_hi),
        .o_acc_lo_c (w_step_lo)
    );

    // Sign fix-up; a zero divisor leaves |a| in the remainder, so only lo is forced.
    always_comb begin
        w_prod_fix = r_neg_q ? ('0 - {r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};
        w_q_fix    = r_dbz ? '1 : (r_neg_q ? ('0 - r_acc_lo) : r_acc_lo);
        w_r_fix    = r_neg_r ? ('0 - r_acc_hi) : r_acc_hi;
        w_res_hi   = r_is_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
        w_res_lo   = r_is_div ? w_q_fix : w_prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_operand <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
        end else begin
            if (w_accept_md) begin
                r_cnt     <= CNT_W'(WIDTH);
                r_is_div  <= w_is_div_op;
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                r_dbz     <= w_is_div_op && (b == '0);
                r_acc_hi  <= '0;
                r_operand <= w_is_div_op ? w_b_mag : w_a_mag;
                r_acc_lo  <= w_is_div_op ? w_a_mag : w_b_mag;
            end else if (w_iter) begin
                r_cnt    <= r_cnt - CNT_W'(1);
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
            end
            if (w_finish) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
            if (w_wr_hi) begin
                r_hi <= a;
            end
            if (w_wr_lo) begin
                r_lo <= a;
            end
            r_busy    <= (w_state_nxt == RUN);
            r_done    <= w_finish;
            r_dbz_out <= w_finish && r_dbz;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz_out;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases at WIDTH=32 and randomised traffic at
// WIDTH=16 and 32 against an arithmetic reference model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start32, cancel32, busy32, done32, dbz32;
    opcode_e     op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start16, cancel16, busy16, done16, dbz16;
    opcode_e     op16;
    logic [15:0] a16, b16, hi16, lo16;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] eh [2];
    logic [63:0] el [2];
    bit          seen;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .op(op32), .a(a32), .b(b32),
        .cancel(cancel32), .busy(busy32), .done(done32), .div_by_zero(dbz32),
        .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .op(op16), .a(a16), .b(b16),
        .cancel(cancel16), .busy(busy16), .done(done16), .div_by_zero(dbz16),
        .hi(hi16), .lo(lo16)
    );

    function automatic int ix(input int w);
        return (w == 16) ? 1 : 0;
    endfunction
    function automatic logic [63:0] get_hi(input int w);
        return (w == 16) ? 64'(hi16) : 64'(hi32);
    endfunction
    function automatic logic [63:0] get_lo(input int w);
        return (w == 16) ? 64'(lo16) : 64'(lo32);
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 16) ? busy16 : busy32;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 16) ? done16 : done32;
    endfunction
    function automatic logic get_dbz(input int w);
        return (w == 16) ? dbz16 : dbz32;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: HI/LO from plain integer arithmetic on the masked operands.
    function automatic void model(input int w, input opcode_e op, input logic [63:0] a_i,
                                  input logic [63:0] b_i, input logic [63:0] hp,
                                  input logic [63:0] lp, output logic [63:0] xh,
                                  output logic [63:0] xl, output logic xd);
        logic [63:0] mask, ua, ub, pu;
        longint      sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = a_i & mask;
        ub   = b_i & mask;
        sa   = longint'(ua << (64 - w)) >>> (64 - w);
        sb   = longint'(ub << (64 - w)) >>> (64 - w);
        xh   = hp;
        xl   = lp;
        xd   = 1'b0;
        case (op)
            MULT:  begin pu = 64'(sa * sb); xh = (pu >> w) & mask; xl = pu & mask; end
            MULTU: begin pu = ua * ub;      xh = (pu >> w) & mask; xl = pu & mask; end
            DIV, DIVU: begin
                if (ub == 64'd0) begin
                    xh = ua; xl = mask; xd = 1'b1;
                end else if (op == DIV) begin
                    q = sa / sb; r = sa % sb;
                    xh = 64'(r) & mask; xl = 64'(q) & mask;
                end else begin
                    xh = ua % ub; xl = ua / ub;
                end
            end
            MTHI: xh = ua;
            MTLO: xl = ua;
            default: ;
        endcase
    endfunction

    task automatic drive(input int w, input opcode_e op, input logic [63:0] a, input logic [63:0] b);
        if (w == 16) begin
            start16 = 1'b1; op16 = op; a16 = 16'(a); b16 = 16'(b);
        end else begin
            start32 = 1'b1; op32 = op; a32 = 32'(a); b32 = 32'(b);
        end
    endtask

    // Advance one edge, then drop requests and scramble operands.
    task automatic settle();
        @(posedge clk);
        #1;
        start32 = 1'b0; cancel32 = 1'b0; start16 = 1'b0; cancel16 = 1'b0;
        a32 = $urandom; b32 = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
        op32 = (op32 == MULT) ? DIVU : MULT;
        op16 = (op16 == MULT) ? DIVU : MULT;
    endtask

    task automatic wait_done(input int w, input int n0, input string tag);
        int n = n0;
        bit busy_ok = 1'b1;
        while (n <= w + 8) begin
            @(posedge clk);
            #1;
            n++;
            if (get_done(w)) break;
            if (!get_busy(w) || get_dbz(w)) busy_ok = 1'b0;
        end
        check({tag, " latency"}, 64'(n), 64'(w + 1));
        check({tag, " busy_in_run"}, 64'(busy_ok), 64'd1);
    endtask

    task automatic check_result(input int w, input string tag, input logic [63:0] xh,
                                input logic [63:0] xl, input logic xd);
        check({tag, " hi"}, get_hi(w), xh);
        check({tag, " lo"}, get_lo(w), xl);
        check({tag, " dbz"}, 64'(get_dbz(w)), 64'(xd));
        check({tag, " busy_at_done"}, 64'(get_busy(w)), 64'd0);
        eh[ix(w)] = xh;
        el[ix(w)] = xl;
    endtask

    task automatic run_op(input int w, input opcode_e op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] xh, input logic [63:0] xl, input logic xd,
                          input string tag);
        drive(w, op, a, b);
        settle();
        wait_done(w, 0, tag);
        check_result(w, tag, xh, xl, xd);
        settle();
        check({tag, " done_one_cycle"}, 64'({get_done(w), get_dbz(w)}), 64'd0);
    endtask

    task automatic run_mt(input int w, input opcode_e op, input logic [63:0] a,
                          input logic [63:0] xh, input logic [63:0] xl, input string tag);
        drive(w, op, a, 64'd0);
        settle();
        check({tag, " hi"}, get_hi(w), xh);
        check({tag, " lo"}, get_lo(w), xl);
        check({tag, " no_busy_done"}, 64'({get_busy(w), get_done(w), get_dbz(w)}), 64'd0);
        eh[ix(w)] = xh;
        el[ix(w)] = xl;
        settle();
        check({tag, " still_idle"}, 64'({get_busy(w), get_done(w)}), 64'd0);
    endtask

    task automatic run_rand(input int w, input string tag);
        opcode_e     op;
        logic [63:0] a, b, xh, xl;
        logic        xd;
        case ($urandom_range(0, 5))
            0: op = MULT;
            1: op = MULTU;
            2: op = DIV;
            3: op = DIVU;
            4: op = MTHI;
            default: op = MTLO;
        endcase
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) begin
            b = 64'd0;
        end else if ($urandom_range(0, 7) == 0) begin
            a = 64'd1 << (w - 1);
            b = '1;
        end
        model(w, op, a, b, eh[ix(w)], el[ix(w)], xh, xl, xd);
        if (op == MTHI || op == MTLO) run_mt(w, op, a, xh, xl, tag);
        else                          run_op(w, op, a, b, xh, xl, xd, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        start32 = 1'b0; cancel32 = 1'b0; op32 = ADDU; a32 = '0; b32 = '0;
        start16 = 1'b0; cancel16 = 1'b0; op16 = ADDU; a16 = '0; b16 = '0;
        eh[0] = '0; el[0] = '0; eh[1] = '0; el[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset32 hi", 64'(hi32), 64'd0);
        check("reset32 lo", 64'(lo32), 64'd0);
        check("reset32 flags", 64'({busy32, done32, dbz32}), 64'd0);
        check("reset16 hilo", {32'(hi16), 32'(lo16)}, 64'd0);
        check("reset16 flags", 64'({busy16, done16, dbz16}), 64'd0);
        reset_n = 1'b1;

        // First start at the first edge with reset released.
        run_op(32, MULT,  64'hFFFFFFFE, 64'd3, 64'hFFFFFFFF, 64'hFFFFFFFA, 1'b0, "mult_neg");
        run_op(32, MULTU, 64'hFFFFFFFE, 64'd3, 64'h00000002, 64'hFFFFFFFA, 1'b0, "multu");
        run_op(32, DIV,   64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 64'hFFFFFFFD, 1'b0, "div_neg");
        run_op(32, DIVU,  64'd7,        64'd2, 64'd1,        64'd3,        1'b0, "divu");
        run_op(32, DIVU,  64'h1234,     64'd0, 64'h1234,     64'hFFFFFFFF, 1'b1, "divu_zero");
        run_op(32, DIV,   64'h80000000, 64'hFFFFFFFF, 64'd0, 64'h80000000, 1'b0, "div_ovf");
        run_op(32, DIV,   64'hFFFFFFF9, 64'd0, 64'hFFFFFFF9, 64'hFFFFFFFF, 1'b1, "div_zero_neg");
        run_op(16, MULT,  64'hFFFE,     64'd3, 64'hFFFF,     64'hFFFA,     1'b0, "mult16_neg");
        run_op(16, DIV,   64'h8000,     64'hFFFF, 64'd0,     64'h8000,     1'b0, "div16_ovf");
        run_mt(32, MTHI, 64'hBEEF, 64'hBEEF, el[0], "mthi");

        // Cancel on the 10th edge of a MULT, with a coincident start that must be dropped.
        drive(32, MULT, 64'h1234, 64'h5678);
        settle();
        repeat (9) settle();
        cancel32 = 1'b1;
        drive(32, MULT, 64'd9, 64'd9);
        settle();
        check("cancel busy_cleared", 64'(busy32), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            settle();
            if (done32 || busy32) seen = 1'b1;
        end
        check("cancel no_done", 64'(seen), 64'd0);
        check("cancel hi_kept", 64'(hi32), eh[0]);
        check("cancel lo_kept", 64'(lo32), el[0]);

        // Back-to-back: second start in the DONE cycle; a start during RUN is ignored.
        drive(32, MULTU, 64'd5, 64'd7);
        settle();
        wait_done(32, 0, "b2b_first");
        drive(32, DIVU, 64'd100, 64'd7);
        check_result(32, "b2b_first", 64'd0, 64'd35, 1'b0);
        settle();
        repeat (4) settle();
        drive(32, MTHI, 64'hDEAD, 64'd0);
        settle();
        wait_done(32, 5, "b2b_second");
        check_result(32, "b2b_second", 64'd2, 64'd14, 1'b0);
        settle();
        check("b2b_second done_one_cycle", 64'({done32, dbz32}), 64'd0);

        // Reset pulsed during a DIV.
        drive(32, DIV, 64'hFFFF0000, 64'd3);
        settle();
        repeat (4) settle();
        reset_n = 1'b0;
        #1;
        check("rst_mid busy", 64'(busy32), 64'd0);
        check("rst_mid hilo", {hi32, lo32}, 64'd0);
        check("rst_mid done", 64'({done32, dbz32}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        eh[0] = '0; el[0] = '0; eh[1] = '0; el[1] = '0;
        seen = 1'b0;
        repeat (40) begin
            settle();
            if (done32 || done16 || busy32) seen = 1'b1;
        end
        check("rst_mid no_done", 64'(seen), 64'd0);
        run_mt(32, MTLO, 64'hCAFE, 64'd0, 64'hCAFE, "mtlo");

        for (int i = 0; i < 40; i++) run_rand(16, $sformatf("rand16_%0d", i));
        for (int i = 0; i < 15; i++) run_rand(32, $sformatf("rand32_%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
